// File: rtl/batch_offset_engine_if.sv
// Put/get handshake bundle for the batch offset engine.
// The master drives words and strobes; the slave answers with ready flags and results.
interface batch_offset_engine_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] put_data;
  logic              EN_put;
  logic              RDY_put;
  logic              EN_get;
  logic              RDY_get;
  logic [DATA_W-1:0] get;

  modport master (
    output put_data, EN_put, EN_get,
    input  RDY_put, RDY_get, get
  );

  modport slave (
    input  put_data, EN_put, EN_get,
    output RDY_put, RDY_get, get
  );
endinterface

// File: rtl/batch_offset_engine.sv
// Batch processor: accumulate DEPTH words, apply a per-batch arithmetic op to each,
// then drain the results through a registered get port.
module batch_offset_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 6,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  batch_offset_engine_if.slave bus,
  input  logic [1:0]          cfg_mode,
  input  logic [DATA_W-1:0]   cfg_offset,
  output logic                ovf,
  output logic [15:0]         batch_cnt,
  output logic                busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {ACCUM, COMPUTE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wrIdx_q, wrIdx_d;
  logic [CNT_W-1:0]  opIdx_q, opIdx_d;
  logic [CNT_W-1:0]  rdIdx_q, rdIdx_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] offset_q, offset_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       batchCnt_q, batchCnt_d;
  logic [DATA_W-1:0] get_q, get_d;

  logic [DATA_W-1:0] inArr  [DEPTH];
  logic [DATA_W-1:0] outArr [DEPTH];

  logic              inWe, outWe;
  logic [DATA_W-1:0] opIn, opResult;
  logic              opOvf;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  rdNext;

  // Datapath for the word currently addressed by opIdx; carry bit doubles as overflow.
  always_comb begin
    opIn     = inArr[opIdx_q[IDX_W-1:0]];
    sum      = {1'b0, opIn} + {1'b0, offset_q};
    opResult = opIn;
    opOvf    = 1'b0;
    case (mode_q)
      2'd0: begin
        opResult = sum[DATA_W-1:0];
        opOvf    = sum[DATA_W];
      end
      2'd1: begin
        opResult = opIn - offset_q;
        opOvf    = (opIn < offset_q);
      end
      2'd2: begin
        opResult = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        opOvf    = sum[DATA_W];
      end
      default: begin
        opResult = opIn;
        opOvf    = 1'b0;
      end
    endcase
  end

  // Next-state logic; strobes that do not match the current state fall through untouched.
  always_comb begin
    state_d    = state_q;
    wrIdx_d    = wrIdx_q;
    opIdx_d    = opIdx_q;
    rdIdx_d    = rdIdx_q;
    mode_d     = mode_q;
    offset_d   = offset_q;
    ovf_d      = ovf_q;
    batchCnt_d = batchCnt_q;
    get_d      = get_q;
    inWe       = 1'b0;
    outWe      = 1'b0;
    rdNext     = rdIdx_q + CNT_W'(1);
    case (state_q)
      ACCUM: begin
        if (bus.EN_put) begin
          inWe = 1'b1;
          if (wrIdx_q == LAST) begin
            wrIdx_d  = '0;
            opIdx_d  = '0;
            mode_d   = cfg_mode;
            offset_d = cfg_offset;
            ovf_d    = 1'b0;
            state_d  = COMPUTE;
          end else begin
            wrIdx_d = wrIdx_q + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        outWe = 1'b1;
        ovf_d = ovf_q | opOvf;
        if (opIdx_q == LAST) begin
          // Word 0 was finished DEPTH-1 cycles ago, so get is valid on FLUSH entry.
          rdIdx_d = '0;
          get_d   = outArr[0];
          state_d = FLUSH;
        end else begin
          opIdx_d = opIdx_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (bus.EN_get) begin
          if (rdIdx_q == LAST) begin
            rdIdx_d    = '0;
            wrIdx_d    = '0;
            get_d      = '0;
            batchCnt_d = batchCnt_q + 16'd1;
            state_d    = ACCUM;
          end else begin
            rdIdx_d = rdNext;
            get_d   = outArr[rdNext[IDX_W-1:0]];
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      wrIdx_q    <= '0;
      opIdx_q    <= '0;
      rdIdx_q    <= '0;
      mode_q     <= '0;
      offset_q   <= '0;
      ovf_q      <= 1'b0;
      batchCnt_q <= '0;
      get_q      <= '0;
    end else begin
      state_q    <= state_d;
      wrIdx_q    <= wrIdx_d;
      opIdx_q    <= opIdx_d;
      rdIdx_q    <= rdIdx_d;
      mode_q     <= mode_d;
      offset_q   <= offset_d;
      ovf_q      <= ovf_d;
      batchCnt_q <= batchCnt_d;
      get_q      <= get_d;
    end
  end

  // Storage arrays carry no reset; the index counters alone define what is valid.
  always_ff @(posedge clk) begin
    if (inWe && !reset) inArr[wrIdx_q[IDX_W-1:0]] <= bus.put_data;
    if (outWe && !reset) outArr[opIdx_q[IDX_W-1:0]] <= opResult;
  end

  assign bus.RDY_put = (state_q == ACCUM);
  assign bus.RDY_get = (state_q == FLUSH);
  assign bus.get     = get_q;
  assign busy        = (state_q == COMPUTE) || (state_q == FLUSH);
  assign ovf         = ovf_q;
  assign batch_cnt   = batchCnt_q;

endmodule
